// File: rtl/pmod_led_pkg.sv
// Shared definitions for the PMOD LED driver.
//   state_t          : controller states IDLE / ARMED / RUN
//   PMOD_WIDTH       : LEDs per PMOD connector
//   LED_COUNT        : total LEDs (PMOD A + PMOD B)
//   PMOD_B_LSB       : first pattern bit routed to PMOD B
//   PMOD_LED_IDX     : pin order; entry p is the pattern bit (within one PMOD byte)
//                      driving output index p (0 = A1, 3 = A4, 4 = A7, 7 = A10)
package pmod_led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int unsigned PMOD_WIDTH = 8;
    localparam int unsigned LED_COUNT  = 16;
    localparam int unsigned PMOD_B_LSB = 8;

    // Straight-through today; edit here if a board rework swaps pins.
    localparam int unsigned PMOD_LED_IDX [PMOD_WIDTH] = '{0, 1, 2, 3, 4, 5, 6, 7};

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: a prescaler dividing the clock into PWM steps, a free-running
// PWM step counter, and a one-cycle pulse marking the last cycle of each period.
//   clk         : clock
//   rst         : asynchronous active-high reset
//   pwm_cnt     : current PWM step, 0 .. 2^PWM_BITS-1
//   period_wrap : high for the single cycle that ends a PWM period
module pwm_timebase #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PRESCALE = 188
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                period_wrap
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]     prescaler_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                step;

    assign step = (prescaler_q == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q <= '0;
            pwm_cnt_q   <= '0;
        end else if (step) begin
            prescaler_q <= '0;
            pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
        end else begin
            prescaler_q <= prescaler_q + PS_W'(1);
        end
    end

    assign pwm_cnt     = pwm_cnt_q;
    assign period_wrap = step && (pwm_cnt_q == '1);

endmodule

// File: rtl/pmod_led_driver.sv
// Drives 16 LEDs on two PMOD connectors with a shared PWM brightness.
// A pattern/brightness pair is accepted over a valid/ready handshake into a
// shadow register and only committed at a PWM period boundary, so the lit
// pattern never changes mid-period. Without new patterns the display blanks
// after TIMEOUT_PERIODS periods.
//   CLK_48     : 48 MHz clock
//   RST        : asynchronous active-high reset
//   in_valid   : upstream offers a pattern
//   in_ready   : pattern accepted when in_valid & in_ready
//   in_pattern : bit i = LED i; [7:0] -> PMOD A, [15:8] -> PMOD B
//   in_bright  : brightness for the pattern
//   led_a      : PMOD A pins A1..A4, A7..A10 (index 0 = A1)
//   led_b      : PMOD B pins, same order
//   active     : high while in RUN
module pmod_led_driver
    import pmod_led_pkg::*;
#(
    parameter int unsigned PWM_BITS        = 8,
    parameter int unsigned PRESCALE        = 188,
    parameter int unsigned TIMEOUT_PERIODS = 1000
) (
    input  logic                CLK_48,
    input  logic                RST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         in_pattern,
    input  logic [PWM_BITS-1:0] in_bright,
    output logic [7:0]          led_a,
    output logic [7:0]          led_b,
    output logic                active
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_PERIODS + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_PERIODS);

    logic [PWM_BITS-1:0]  pwm_cnt;
    logic                 period_wrap;

    state_t               state_q, state_d;
    logic                 pending_q, pending_d;
    logic                 ready_q;
    logic [LED_COUNT-1:0] shadow_pat_q;
    logic [PWM_BITS-1:0]  shadow_br_q;
    logic [LED_COUNT-1:0] act_pat_q, act_pat_d;
    logic [PWM_BITS-1:0]  act_br_q, act_br_d;
    logic [TO_W-1:0]      timeout_q, timeout_d, timeout_inc;
    logic [LED_COUNT-1:0] led_q, led_d;
    logic                 active_q;
    logic                 xfer, commit, lit;

    pwm_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk         (CLK_48),
        .rst         (RST),
        .pwm_cnt     (pwm_cnt),
        .period_wrap (period_wrap)
    );

    // ready_q is ~pending_q, so a transfer and a commit never share a cycle:
    // data landing on a wrap cycle waits for the following wrap.
    assign xfer   = in_valid && ready_q;
    assign commit = period_wrap && pending_q;

    assign timeout_inc = (timeout_q == TO_MAX) ? timeout_q : timeout_q + TO_W'(1);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        act_pat_d = act_pat_q;
        act_br_d  = act_br_q;
        timeout_d = timeout_q;

        if (xfer) begin
            pending_d = 1'b1;
        end else if (commit) begin
            pending_d = 1'b0;
            act_pat_d = shadow_pat_q;
            act_br_d  = shadow_br_q;
        end

        unique case (state_q)
            IDLE: begin
                if (xfer) state_d = ARMED;
            end
            ARMED: begin
                if (commit) begin
                    state_d   = RUN;
                    timeout_d = '0;
                end
            end
            RUN: begin
                if (commit) begin
                    timeout_d = '0;
                end else if (period_wrap) begin
                    if (timeout_inc == TO_MAX) begin
                        // A pattern accepted on this same wrap must not strand in IDLE.
                        state_d   = xfer ? ARMED : IDLE;
                        timeout_d = '0;
                        act_pat_d = '0;
                        act_br_d  = '0;
                    end else begin
                        timeout_d = timeout_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All-ones brightness means fully on, including the last PWM step.
    assign lit   = (pwm_cnt < act_br_q) || (act_br_q == '1);
    assign led_d = ((state_q == RUN) && lit) ? act_pat_q : '0;

    always_ff @(posedge CLK_48 or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            ready_q      <= 1'b1;
            shadow_pat_q <= '0;
            shadow_br_q  <= '0;
            act_pat_q    <= '0;
            act_br_q     <= '0;
            timeout_q    <= '0;
            led_q        <= '0;
            active_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ready_q   <= ~pending_d;
            if (xfer) begin
                shadow_pat_q <= in_pattern;
                shadow_br_q  <= in_bright;
            end
            act_pat_q <= act_pat_d;
            act_br_q  <= act_br_d;
            timeout_q <= timeout_d;
            led_q     <= led_d;
            active_q  <= (state_d == RUN);
        end
    end

    always_comb begin
        led_a = '0;
        led_b = '0;
        for (int p = 0; p < PMOD_WIDTH; p++) begin
            led_a[p] = led_q[PMOD_LED_IDX[p]];
            led_b[p] = led_q[PMOD_B_LSB + PMOD_LED_IDX[p]];
        end
    end

    assign in_ready = ready_q;
    assign active   = active_q;

endmodule

// File: tb/tb_pmod_led_driver.sv
// Self-checking bench for pmod_led_driver (PWM_BITS=4, PRESCALE=2, TIMEOUT_PERIODS=3).
// Accepted patterns are pushed to a scoreboard queue and popped at the period
// wrap where they must become visible; every cycle the LED outputs, active and
// in_ready are compared against values derived from the scoreboard and a
// cycle count since reset release.
module tb_pmod_led_driver;

    localparam int PB = 4;
    localparam int PS = 2;
    localparam int TO = 3;
    localparam int PERIOD = PS * 16;
    localparam int M_IDLE = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_pattern = '0;
    logic [PB-1:0] in_bright = '0;
    logic [7:0]    led_a, led_b;
    logic          active;

    pmod_led_driver #(
        .PWM_BITS        (PB),
        .PRESCALE        (PS),
        .TIMEOUT_PERIODS (TO)
    ) dut (
        .CLK_48     (clk),
        .RST        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pattern (in_pattern),
        .in_bright  (in_bright),
        .led_a      (led_a),
        .led_b      (led_b),
        .active     (active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: {bright, pattern} accepted but not yet committed.
    logic [19:0] sb_q[$];
    int          m_cyc;
    int          m_st;
    int          m_to;
    logic [15:0] m_pat;
    logic [3:0]  m_br;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit wrap_now();
        return ((m_cyc % PS) == PS - 1) && (((m_cyc / PS) % 16) == 15);
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_cyc = 0;
        m_st  = M_IDLE;
        m_to  = 0;
        m_pat = '0;
        m_br  = '0;
    endtask

    // Advance one clock; the model steps from the pre-edge inputs and state.
    task automatic step();
        int          pwm;
        logic        wrap, xfer, commit;
        logic [15:0] nled;
        logic [19:0] ent;
        pwm    = (m_cyc / PS) % 16;
        wrap   = wrap_now();
        xfer   = in_valid && (sb_q.size() == 0);
        commit = wrap && (sb_q.size() != 0);
        nled   = '0;
        if (m_st == M_RUN && (pwm < int'(m_br) || m_br == 4'hF)) nled = m_pat;
        if (commit) begin
            ent   = sb_q.pop_front();
            m_pat = ent[15:0];
            m_br  = ent[19:16];
            m_st  = M_RUN;
            m_to  = 0;
        end else if (wrap && m_st == M_RUN) begin
            m_to++;
            if (m_to >= TO) begin
                m_to  = 0;
                m_pat = '0;
                m_br  = '0;
                m_st  = M_IDLE;
            end
        end
        if (xfer) begin
            sb_q.push_back({in_bright, in_pattern});
            if (m_st == M_IDLE) m_st = M_ARMED;
        end
        m_cyc++;
        @(posedge clk);
        @(negedge clk);
        check("led_a", 32'(led_a), 32'(nled[7:0]));
        check("led_b", 32'(led_b), 32'(nled[15:8]));
        check("active", 32'(active), 32'(m_st == M_RUN));
        check("in_ready", 32'(in_ready), 32'(sb_q.size() == 0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold a pattern on the bus until the model says it was taken.
    task automatic offer(input logic [15:0] p, input logic [3:0] b, output int n);
        bit acc;
        in_pattern = p;
        in_bright  = b;
        in_valid   = 1'b1;
        n = 0;
        forever begin
            acc = (sb_q.size() == 0);
            step();
            n++;
            if (acc) break;
            if (n >= 200) begin
                check("offer_timeout", 32'(n), 32'(0));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_commit();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) step();
        check("commit_reached", 32'(sb_q.size()), 32'(0));
    endtask

    int n, n2, hi;

    initial begin
        model_reset();
        @(negedge clk);
        check("rst_led_a", 32'(led_a), 32'(0));
        check("rst_led_b", 32'(led_b), 32'(0));
        check("rst_active", 32'(active), 32'(0));
        check("rst_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run(3);

        // Full brightness pattern: accepted at once, steady on after the wrap.
        offer(16'hA5C3, 4'hF, n);
        check("accept_latency", 32'(n), 32'(1));
        check("ready_low_after_accept", 32'(in_ready), 32'(0));
        wait_commit();
        run(2 * PERIOD);
        check("steady_led_a", 32'(led_a), 32'h0C3);
        check("steady_led_b", 32'(led_b), 32'h0A5);
        check("steady_active", 32'(active), 32'(1));

        // Quarter duty: 8 of 32 cycles lit.
        offer(16'hFFFF, 4'h4, n);
        wait_commit();
        run(3);
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step();
            if (led_a != 8'h00 && led_b != 8'h00) hi++;
        end
        check("duty_cycles", 32'(hi), 32'(8));

        // Transfer landing exactly on a wrap: old pattern kept a full period.
        for (int i = 0; i < 2 * PERIOD && !wrap_now(); i++) step();
        check("on_wrap_align", 32'(wrap_now()), 32'(1));
        offer(16'h1234, 4'hF, n);
        check("on_wrap_queued", 32'(sb_q.size()), 32'(1));
        run(2 * PERIOD + 4);

        // Second pattern while first pending: back-pressure, no loss.
        offer(16'h0F0F, 4'hF, n);
        offer(16'hF0F0, 4'hF, n2);
        check("second_waited", 32'(n2 > 1), 32'(1));
        wait_commit();
        run(4);
        check("second_led_a", 32'(led_a), 32'h0F0);

        // Timeout after three idle periods, then re-arm.
        run((TO + 1) * PERIOD + 8);
        check("timeout_active", 32'(active), 32'(0));
        check("timeout_led_a", 32'(led_a), 32'(0));
        check("timeout_led_b", 32'(led_b), 32'(0));
        offer(16'h00FF, 4'hF, n);
        check("rearm_state", 32'(m_st), 32'(M_ARMED));
        wait_commit();
        run(4);
        check("rearm_active", 32'(active), 32'(1));
        check("rearm_led_a", 32'(led_a), 32'h0FF);

        // Reset mid-period with a pattern pending.
        run(5);
        offer(16'h5555, 4'hF, n);
        check("pending_before_rst", 32'(sb_q.size()), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("async_led_a", 32'(led_a), 32'(0));
        check("async_led_b", 32'(led_b), 32'(0));
        check("async_active", 32'(active), 32'(0));
        check("async_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run(3 * PERIOD);
        check("post_rst_led_a", 32'(led_a), 32'(0));
        check("post_rst_active", 32'(active), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmod_led_driver.md
PMOD_LED_DRIVER -- requirements
Module: pmod_led_driver

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8: PWM resolution in bits.
REQ-002 SHALL have parameter PRESCALE, default 188: CLK_48 cycles per PWM step, giving about 1 kHz PWM at 8 bits.
REQ-003 SHALL have parameter TIMEOUT_PERIODS, default 1000: PWM periods without a new pattern before blanking.
REQ-004 SHALL have port CLK_48, input, 1: sole clock, 48 MHz.
REQ-005 SHALL have port RST, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1: upstream offers a pattern.
REQ-007 SHALL have port in_ready, output, 1: block accepts a pattern this cycle.
REQ-008 SHALL have port in_pattern, input, 16: bit i is LED i; bits 7:0 go to PMOD A, bits 15:8 go to PMOD B.
REQ-009 SHALL have port in_bright, input, PWM_BITS: brightness captured with the pattern.
REQ-010 SHALL have port led_a, output, 8: PMOD A pins A1..A4, A7..A10, index 0 = A1.
REQ-011 SHALL have port led_b, output, 8: PMOD B pins, same order as led_a.
REQ-012 SHALL have port active, output, 1: high in RUN state.

Function
REQ-013 SHALL run a timebase: prescaler counts 0..PRESCALE-1, and pwm_cnt increments at each prescaler wrap, modulo 2^PWM_BITS.
REQ-014 SHALL assert the period-wrap pulse for one cycle when the prescaler wraps and pwm_cnt equals all-ones.
REQ-015 SHALL complete a transfer on any cycle with in_valid and in_ready both high, capturing in_pattern and in_bright into a shadow register and setting pending.
REQ-016 SHALL drive in_ready = ~pending, registered; in_ready SHALL fall on the cycle after acceptance.
REQ-017 SHALL copy shadow to the active registers and clear pending only on a period-wrap cycle; active values SHALL never change mid-period.
REQ-018 SHALL, when a transfer and a period-wrap fall in the same cycle, place the new data in shadow and commit it at the next period-wrap, not the current one.
REQ-019 SHALL have states IDLE, ARMED and RUN.
REQ-020 SHALL transition IDLE to ARMED on a transfer.
REQ-021 SHALL transition ARMED to RUN on a period-wrap commit.
REQ-022 SHALL, in RUN, commit a pending pattern on period-wrap, stay in RUN and reset the timeout counter.
REQ-023 SHALL, in RUN with no commit, increment the timeout counter per period-wrap; on reaching TIMEOUT_PERIODS it SHALL go to IDLE and clear the active pattern.
REQ-024 SHALL saturate the timeout counter and never let it wrap.
REQ-025 SHALL, in RUN, drive output bit i = active_pattern[i] AND (pwm_cnt < active_bright), registered with 1 cycle latency.
REQ-026 SHALL keep outputs low for active_bright = 0, and hold outputs continuously on for active_bright = all-ones.
REQ-027 SHALL hold led_a, led_b = 0 in IDLE and ARMED.
REQ-028 SHALL drive active = (state == RUN), registered.

Reset
REQ-029 SHALL, on RST high, immediately force: state IDLE, led_a = 0, led_b = 0, active = 0, in_ready = 1, pending = 0, prescaler = 0, pwm_cnt = 0, timeout = 0, shadow = 0, active registers = 0.
REQ-030 SHALL, on RST asserted mid-transfer or mid-period, discard pending data; no partial commit SHALL occur after reset release.
REQ-031 SHALL let the first period after reset release start at pwm_cnt = 0.

Structure
REQ-032 SHALL place the state enum (IDLE, ARMED, RUN) and the PMOD pin-order constant in a shared package, pmod_led_pkg.
REQ-033 SHALL implement the prescaler, pwm_cnt and period-wrap pulse in one sub-module, pwm_timebase.
REQ-034 SHALL keep the handshake, FSM and output compare in pmod_led_driver.

Verification
Bench configuration: PWM_BITS=4, PRESCALE=2, TIMEOUT_PERIODS=3.
REQ-035 SHALL cover: reset release, pattern 16'hA5C3 with bright 4'hF offered -> accepted at once, in_ready low; led_a = 8'hC3 and led_b = 8'hA5 continuously, starting 1 cycle after the first period-wrap; active = 1.
REQ-036 SHALL cover: pattern 16'hFFFF with bright 4'h4 -> each output high for exactly 8 of 32 cycles per period, aligned to pwm_cnt 0..3.
REQ-037 SHALL cover: transfer landing on the period-wrap cycle -> old pattern held for one full further period, new pattern visible after the next wrap.
REQ-038 SHALL cover: second pattern offered while pending -> in_ready stays low until commit, and no data is lost or duplicated.
REQ-039 SHALL cover: no new pattern for 3 periods in RUN -> outputs go to 0, active = 0, and a subsequent pattern passes through ARMED and back to RUN.
REQ-040 SHALL cover: RST pulsed mid-period with pattern pending -> all outputs 0 asynchronously, in_ready = 1, and the pending pattern never appears.
